// File: rtl/fifo_uart_tx.sv
// 8N1 serial transmitter that drains bytes from a single-clock FIFO read port
// (rd_en / empty / registered data with one cycle of latency).
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] bytes_sent
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    // NOTE: every _d defaults to its _q first, so no branch can leave a
    // variable unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_LOAD;
            end

            // Read data arrives this cycle; the start bit begins on the same edge.
            S_LOAD: begin
                shift_d = fifo_data;
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = S_START;
            end

            S_START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            // The FIFO is re-sampled only on the last stop-bit cycle.
            S_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = fifo_empty ? S_IDLE : S_FETCH;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign fifo_rd_en = (state_q == S_FETCH);
    assign busy       = (state_q != S_IDLE);
    assign tx_done    = (state_q == S_STOP) && bit_end;
    assign tx         = tx_q;
    assign bytes_sent = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: a FIFO model feeds the transmitter, a line monitor decodes
// every frame cycle by cycle and compares it against the bytes that were queued.
module tb_fifo_uart_tx;

    localparam int C     = 4;
    localparam int CW    = 4;
    localparam int FRAME = 10 * C;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [7:0]    fifo_data  = 8'h00;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          tx_done;
    logic [CW-1:0] bytes_sent;

    logic       wr_req  = 1'b0;
    logic [7:0] wr_byte = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         gap_q[$];
    int         rd_pulses   = 0;
    int         underflows  = 0;
    int         mon_pos     = -1;
    int         frames_seen = 0;

    fifo_uart_tx #(
        .CLKS_PER_BIT(C),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done),
        .bytes_sent(bytes_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single-clock FIFO: registered read data, empty flag updated on the edge.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_pulses++;
            if (fifo_q.size() == 0) underflows++;
            else fifo_data <= fifo_q.pop_front();
        end
        if (wr_req) fifo_q.push_back(wr_byte);
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Line monitor: a frame is start 0, eight data bits LSB first, stop 1,
    // each held C cycles; tx_done marks the final cycle and bumps the count.
    logic [CW-1:0] exp_sent  = '0;
    logic [9:0]    exp_frame = '0;
    int            high_run  = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_pos  = -1;
                high_run = 0;
                exp_sent = '0;
            end else begin
                check("bytes_sent", bytes_sent, exp_sent);
                if (mon_pos < 0) begin
                    if (tx === 1'b0) begin
                        check("frame_expected", exp_q.size() > 0, 1'b1);
                        exp_frame = {1'b1, (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00, 1'b0};
                        gap_q.push_back(C + high_run);
                        mon_pos = 0;
                    end else begin
                        check("tx_done_idle", tx_done, 1'b0);
                        high_run++;
                    end
                end
                if (mon_pos >= 0) begin
                    check("tx_bit", tx, exp_frame[mon_pos / C]);
                    check("tx_done", tx_done, mon_pos == FRAME - 1);
                    if (mon_pos == FRAME - 1) begin
                        exp_sent++;
                        frames_seen++;
                        mon_pos  = -1;
                        high_run = 0;
                    end else begin
                        mon_pos++;
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        wr_req  = 1'b1;
        wr_byte = b;
        exp_q.push_back(b);
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_bytes_sent", bytes_sent, '0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            done = (busy === 1'b0) && (fifo_empty === 1'b1) && (mon_pos < 0) && (exp_q.size() == 0);
        end
        check({name, "_idle_reached"}, done, 1'b1);
    endtask

    task automatic wait_pos(input string name, input int pos, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            #1;
            hit = (mon_pos == pos);
        end
        check({name, "_pos_reached"}, hit, 1'b1);
    endtask

    int rd0;
    int fr0;
    int rd_seen;
    int tx_low;
    int busy_seen;
    int done_seen;

    initial begin : stimulus
        // Initial reset, raised before the first sampling edge.
        #1 rst = 1'b1;
        #1;
        check("init_tx", tx, 1'b1);
        check("init_busy", busy, 1'b0);
        check("init_tx_done", tx_done, 1'b0);
        check("init_rd_en", fifo_rd_en, 1'b0);
        check("init_bytes_sent", bytes_sent, '0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // 1: single byte 0xA5, with latency from empty falling to start bit.
        rd0 = rd_pulses;
        push(8'hA5);
        check("t1_still_idle", busy, 1'b0);
        @(negedge clk);
        check("t1_fetch_rd_en", fifo_rd_en, 1'b1);
        check("t1_fetch_tx", tx, 1'b1);
        check("t1_fetch_busy", busy, 1'b1);
        @(negedge clk);
        check("t1_load_rd_en", fifo_rd_en, 1'b0);
        check("t1_load_tx", tx, 1'b1);
        @(negedge clk);
        check("t1_start_tx", tx, 1'b0);
        wait_idle("t1", 200);
        check("t1_rd_pulses", rd_pulses - rd0, 1);
        check("t1_bytes_sent", bytes_sent, 1);
        check("t1_busy", busy, 1'b0);

        // 2: three back-to-back bytes with a C+2 cycle high gap.
        do_reset();
        gap_q.delete();
        rd0 = rd_pulses;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        wait_idle("t2", 400);
        check("t2_bytes_sent", bytes_sent, 3);
        check("t2_rd_pulses", rd_pulses - rd0, 3);
        check("t2_frames", gap_q.size(), 3);
        if (gap_q.size() == 3) begin
            check("t2_gap1", gap_q[1], C + 2);
            check("t2_gap2", gap_q[2], C + 2);
        end

        // 3: FIFO stays empty, line stays idle.
        do_reset();
        rd0       = rd_pulses;
        rd_seen   = 0;
        tx_low    = 0;
        busy_seen = 0;
        done_seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0) rd_seen++;
            if (tx !== 1'b1) tx_low++;
            if (busy !== 1'b0) busy_seen++;
            if (tx_done !== 1'b0) done_seen++;
        end
        check("t3_rd_en_cycles", rd_seen, 0);
        check("t3_tx_low_cycles", tx_low, 0);
        check("t3_busy_cycles", busy_seen, 0);
        check("t3_tx_done_cycles", done_seen, 0);
        check("t3_rd_pulses", rd_pulses - rd0, 0);

        // 4: reset mid-DATA of 0x55; 0x77 left in the FIFO goes out next.
        do_reset();
        rd0 = rd_pulses;
        fr0 = frames_seen;
        push(8'h55);
        push(8'h77);
        wait_pos("t4", 3 * C, 200);
        do_reset();
        wait_idle("t4", 300);
        check("t4_bytes_sent", bytes_sent, 1);
        check("t4_rd_pulses", rd_pulses - rd0, 2);
        check("t4_frames", frames_seen - fr0, 1);

        // 5: byte written while the previous frame is mid-stop-bit.
        do_reset();
        gap_q.delete();
        rd0 = rd_pulses;
        push(8'h96);
        wait_pos("t5", 9 * C + 1, 200);
        push(8'h3B);
        wait_idle("t5", 300);
        check("t5_rd_pulses", rd_pulses - rd0, 2);
        check("t5_frames", gap_q.size(), 2);
        if (gap_q.size() == 2) check("t5_gap", gap_q[1], C + 2);
        check("t5_bytes_sent", bytes_sent, 2);

        // 6: 17 random bytes wrap the 4-bit counter to 1.
        do_reset();
        rd0 = rd_pulses;
        fr0 = frames_seen;
        for (int i = 0; i < 17; i++) push(8'($urandom_range(0, 255)));
        wait_idle("t6", 2000);
        check("t6_bytes_sent_wrap", bytes_sent, 1);
        check("t6_rd_pulses", rd_pulses - rd0, 17);
        check("t6_frames", frames_seen - fr0, 17);

        check("no_underflow", underflows, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the team's single-clock byte FIFO. It drains bytes through the FIFO's read port: read enable, empty flag, and registered read data with 1-cycle latency. Each byte goes out as an 8N1 asynchronous serial frame. It sits between the FIFO and a board-level TX pin and is the transmit counterpart to any FIFO-fed UART receiver.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
CNT_W, 16, width of bytes_sent counter.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  8  FIFO registered read data; valid the cycle after fifo_rd_en was high.
fifo_rd_en  output  1  FIFO read enable; high for exactly one cycle per byte fetched.
tx  output  1  serial line; idle high.
busy  output  1  high whenever state is not IDLE.
tx_done  output  1  one-cycle pulse at the end of each stop bit.
bytes_sent  output  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset, asynchronous, effective immediately:
  - state = IDLE, tx = 1, fifo_rd_en = 0, busy = 0, tx_done = 0, bytes_sent = 0.
  - Baud counter, bit index and shift register = 0.
- Reset mid-frame aborts the frame. tx returns high at once, the byte is lost, and no tx_done is produced.
- All outputs are registered or decoded from registered state. No combinational path from fifo_empty or fifo_data to any output.
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE:
  - tx = 1.
  - If fifo_empty == 0, go to FETCH next cycle; otherwise stay in IDLE.
- FETCH (1 cycle): fifo_rd_en = 1. Always go to LOAD.
- LOAD (1 cycle):
  - fifo_data is valid; shift register <= fifo_data.
  - tx <= 0 on the same edge; go to START.
  - Baud counter <= 0.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift register bit 0, LSB first.
  - Each bit is held CLKS_PER_BIT cycles, then the register shifts right and the bit index increments.
  - After bit index 7 completes, go to STOP with tx <= 1.
- STOP: tx = 1 for CLKS_PER_BIT cycles. On its last cycle:
  - tx_done = 1 and bytes_sent increments.
  - If fifo_empty == 0, go to FETCH; otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1; it wraps to 0 on each bit boundary and is reset on entry to START.
- Latency from fifo_empty falling (sampled in IDLE) to tx falling: 3 clk edges (IDLE->FETCH->LOAD->START).
- Frame length: exactly 10*CLKS_PER_BIT cycles of tx, from start-bit fall to stop-bit end.
- Back-to-back bytes: tx stays high for CLKS_PER_BIT + 2 cycles between frames (stop bit plus FETCH and LOAD).
- fifo_rd_en is never asserted unless fifo_empty was sampled 0 on the preceding edge, so the FIFO is never underflowed.
- fifo_empty changing during START, DATA or STOP has no effect; it is only sampled in IDLE and on STOP's last cycle.
- fifo_data is only sampled in LOAD and is ignored in all other states.
- bytes_sent wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
1. CLKS_PER_BIT=4, FIFO preloaded with 0xA5, all other defaults:
   - Exactly one fifo_rd_en pulse.
   - tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
   - tx_done pulses once; bytes_sent = 1; busy falls after the stop bit; FIFO empty.
2. FIFO preloaded with 0x00, 0xFF, 0x3C:
   - Three frames; tx high for exactly 6 cycles between frames.
   - Data bits 00000000, 11111111, 00111100 (LSB first).
   - bytes_sent = 3; fifo_rd_en asserted 3 times total.
3. FIFO empty for 200 cycles -> fifo_rd_en never asserted; tx = 1; busy = 0; tx_done = 0.
4. Assert rst during the DATA state of byte 0x55:
   - tx = 1 immediately; busy = 0; bytes_sent = 0; no tx_done.
   - After rst deasserts with the FIFO still holding 0x77, the next frame carries 0x77.
5. Write one byte while a frame is in STOP, fifo_empty falling mid-STOP -> on STOP's last cycle the block goes directly to FETCH; inter-frame gap = CLKS_PER_BIT + 2 cycles.
6. CNT_W=4, send 17 bytes -> bytes_sent reads 1 after the 17th tx_done (wrapped); every frame bit-exact.
